// File: rtl/vdc_pkg.sv
// Shared types and width helpers for the streaming Van der Corput generator.
package vdc_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StDigGo,
    StDigWait,
    StFrcGo,
    StFrcWait,
    StOut
  } vdc_state_e;

  // Width of the reversed integer R and the power P = base^ndigits.
  function automatic int unsigned vdc_pw(input int unsigned width, input int unsigned base_w);
    return width + base_w;
  endfunction

  // Dividend width of the shared divider: the fraction divide needs R << FRAC.
  function automatic int unsigned vdc_div_nw(input int unsigned frac, input int unsigned pw);
    return frac + pw;
  endfunction

  function automatic int unsigned vdc_cnt_w(input int unsigned nw);
    return $clog2(nw + 1);
  endfunction

endpackage

// File: rtl/vdc_seq_div.sv
// Restoring sequential divider, one quotient bit per cycle. The first bit is
// resolved on the start edge, so an nbits-wide divide takes nbits edges.
module vdc_seq_div
  import vdc_pkg::*;
#(
  parameter int unsigned NW = 56,
  parameter int unsigned DW = 40,
  parameter int unsigned CW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [NW-1:0] dividend,
  input  logic [DW-1:0] divisor,
  input  logic [CW-1:0] nbits,
  output logic [NW-1:0] quot,
  output logic [DW-1:0] rem,
  output logic          done
);

  logic [NW-1:0] dvd_q, dvd_d, quot_q, quot_d;
  logic [DW-1:0] rem_q, rem_d, dsr_q, dsr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;

  logic [NW-1:0] src_dvd, src_quot;
  logic [DW-1:0] src_rem, src_dsr;
  logic [DW:0]   trial;
  logic [CW-1:0] shamt;
  logic          fire;

  always_comb begin
    // Left-align the significant dividend bits so the MSB is always consumed first.
    shamt    = CW'(NW) - nbits;
    fire     = start | (cnt_q != '0);
    src_dvd  = start ? (dividend << shamt) : dvd_q;
    src_quot = start ? '0 : quot_q;
    src_rem  = start ? '0 : rem_q;
    src_dsr  = start ? divisor : dsr_q;
    trial    = {src_rem, src_dvd[NW-1]};

    dvd_d  = dvd_q;
    quot_d = quot_q;
    rem_d  = rem_q;
    dsr_d  = dsr_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;

    if (fire) begin
      if (trial >= {1'b0, src_dsr}) begin
        rem_d  = DW'(trial - {1'b0, src_dsr});
        quot_d = {src_quot[NW-2:0], 1'b1};
      end else begin
        rem_d  = trial[DW-1:0];
        quot_d = {src_quot[NW-2:0], 1'b0};
      end
      dvd_d  = src_dvd << 1;
      dsr_d  = src_dsr;
      cnt_d  = start ? (nbits - CW'(1)) : (cnt_q - CW'(1));
      done_d = (cnt_d == '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvd_q  <= '0;
      quot_q <= '0;
      rem_q  <= '0;
      dsr_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      dvd_q  <= dvd_d;
      quot_q <= quot_d;
      rem_q  <= rem_d;
      dsr_q  <= dsr_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign quot = quot_q;
  assign rem  = rem_q;
  assign done = done_q;

endmodule

// File: rtl/vdcorput_stream_div.sv
// Streaming Van der Corput generator with runtime base: emits seed_count exact
// points floor(R*2^FRAC/P) for consecutive indices, with valid/ready output.
module vdcorput_stream_div
  import vdc_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned FRAC   = 32,
  parameter int unsigned BASE_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              seed_valid,
  output logic              seed_ready,
  input  logic [WIDTH-1:0]  seed_k,
  input  logic [BASE_W-1:0] seed_base,
  input  logic [WIDTH-1:0]  seed_count,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [FRAC-1:0]   out_data,
  output logic [WIDTH-1:0]  out_k,
  output logic              out_last,
  output logic              err_base
);

  localparam int unsigned PW = vdc_pw(WIDTH, BASE_W);
  localparam int unsigned NW = vdc_div_nw(FRAC, PW);
  localparam int unsigned CW = vdc_cnt_w(NW);

  vdc_state_e        state_q, state_d;
  logic [WIDTH-1:0]  k_q, k_d, kw_q, kw_d, remaining_q, remaining_d;
  logic [BASE_W-1:0] base_q, base_d;
  logic [PW-1:0]     r_q, r_d, p_q, p_d;
  logic [FRAC-1:0]   data_q, data_d;
  logic              err_q, err_d;

  logic [PW-1:0]     base_ext;
  logic [WIDTH-1:0]  k_inc;
  logic              div_start, div_done;
  logic [NW-1:0]     div_dividend, div_quot;
  logic [PW-1:0]     div_divisor, div_rem;
  logic [CW-1:0]     div_nbits;
  logic              unused_div;

  assign base_ext   = PW'(base_q);
  assign k_inc      = k_q + WIDTH'(1);
  assign unused_div = ^div_quot;

  vdc_seq_div #(
    .NW(NW),
    .DW(PW),
    .CW(CW)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (div_dividend),
    .divisor  (div_divisor),
    .nbits    (div_nbits),
    .quot     (div_quot),
    .rem      (div_rem),
    .done     (div_done)
  );

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    kw_d         = kw_q;
    remaining_d  = remaining_q;
    base_d       = base_q;
    r_d          = r_q;
    p_d          = p_q;
    data_d       = data_q;
    err_d        = 1'b0;
    div_start    = 1'b0;
    div_dividend = '0;
    div_divisor  = '0;
    div_nbits    = '0;

    case (state_q)
      StIdle: begin
        if (seed_valid) begin
          err_d       = (seed_base < BASE_W'(2));
          k_d         = seed_k;
          kw_d        = seed_k;
          base_d      = seed_base;
          remaining_d = seed_count;
          r_d         = '0;
          p_d         = PW'(1);
          if ((seed_base >= BASE_W'(2)) && (seed_count != '0)) begin
            state_d = (seed_k == '0) ? StFrcGo : StDigGo;
          end
        end
      end
      StDigGo: begin
        div_start    = 1'b1;
        div_dividend = NW'(kw_q);
        div_divisor  = base_ext;
        div_nbits    = CW'(WIDTH);
        state_d      = StDigWait;
      end
      StDigWait: begin
        if (div_done) begin
          r_d     = r_q * base_ext + div_rem;
          p_d     = p_q * base_ext;
          kw_d    = div_quot[WIDTH-1:0];
          state_d = (div_quot[WIDTH-1:0] == '0) ? StFrcGo : StDigGo;
        end
      end
      StFrcGo: begin
        // R < P, so the quotient of (R << FRAC) / P fits in FRAC bits.
        div_start    = 1'b1;
        div_dividend = {r_q, {FRAC{1'b0}}};
        div_divisor  = p_q;
        div_nbits    = CW'(NW);
        state_d      = StFrcWait;
      end
      StFrcWait: begin
        if (div_done) begin
          data_d  = div_quot[FRAC-1:0];
          state_d = StOut;
        end
      end
      StOut: begin
        if (out_ready) begin
          if (remaining_q > WIDTH'(1)) begin
            k_d         = k_inc;
            kw_d        = k_inc;
            remaining_d = remaining_q - WIDTH'(1);
            r_d         = '0;
            p_d         = PW'(1);
            state_d     = (k_inc == '0) ? StFrcGo : StDigGo;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      k_q         <= '0;
      kw_q        <= '0;
      remaining_q <= '0;
      base_q      <= '0;
      r_q         <= '0;
      p_q         <= '0;
      data_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      kw_q        <= kw_d;
      remaining_q <= remaining_d;
      base_q      <= base_d;
      r_q         <= r_d;
      p_q         <= p_d;
      data_q      <= data_d;
      err_q       <= err_d;
    end
  end

  assign seed_ready = (state_q == StIdle);
  assign out_valid  = (state_q == StOut);
  assign out_data   = data_q;
  assign out_k      = k_q;
  assign out_last   = out_valid && (remaining_q == WIDTH'(1));
  assign err_base   = err_q;

endmodule
